// File: rtl/id_allocator_pkg.sv
// id_allocator_pkg: shared types and sizing for the instruction-ID allocator
package id_allocator_pkg;

   localparam int MAX_IDS = 8;
   localparam int ID_W    = $clog2(MAX_IDS);

   typedef logic [ID_W-1:0] id_t;

   typedef enum logic {
      NORMAL = 1'b0,
      REFILL = 1'b1
   } id_alloc_state_t;

endpackage

// File: rtl/id_toggle_bank.sv
// id_toggle_bank: per-ID toggle bits with one toggle port and two read ports
module id_toggle_bank #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         toggle,
   input  logic [W-1:0] toggle_id,
   input  logic [W-1:0] rd_a_id,
   input  logic [W-1:0] rd_b_id,
   output logic         rd_a,
   output logic         rd_b
);

   logic [N-1:0] bits;

   // flip the addressed bit; comparing two banks yields in-flight state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bits <= '0;
      else if (toggle) bits[toggle_id] <= ~bits[toggle_id];
   end

   assign rd_a = bits[rd_a_id];
   assign rd_b = bits[rd_b_id];

endmodule

// File: rtl/id_allocator.sv
// id_allocator: free-list FIFO of instruction IDs with flush-driven refill
module id_allocator #(
   parameter  int MAX_IDS = id_allocator_pkg::MAX_IDS,
   localparam int ID_W    = $clog2(MAX_IDS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc_req,
   output logic            id_available,
   output logic [ID_W-1:0] alloc_id,
   input  logic            retire,
   input  logic [ID_W-1:0] retire_id,
   input  logic            flush,
   output logic            busy,
   input  logic [ID_W-1:0] query_id,
   output logic            query_inflight,
   output logic [ID_W:0]   inflight_count,
   output logic            retire_error
);

   import id_allocator_pkg::*;

   logic [ID_W-1:0] fifo [MAX_IDS];
   logic [ID_W-1:0] rd_ptr, wr_ptr, idx, chk_id;
   logic [ID_W:0]   free_count;
   id_alloc_state_t state, state_nx;
   logic            refill, last_idx;
   logic            iss_q, ret_q, iss_c, ret_c, chk_inflight;
   logic            alloc_fire, retire_fire, retire_bad, clr_fire;

   // during refill the retire-side read port walks idx instead of retire_id
   assign refill       = state == REFILL;
   assign last_idx     = idx == ID_W'(MAX_IDS - 1);
   assign chk_id       = refill ? idx : retire_id;
   assign chk_inflight = iss_c ^ ret_c;
   assign alloc_fire   = alloc_req && id_available && !flush;
   assign retire_fire  = !refill && !flush && retire && chk_inflight;
   assign retire_bad   = !refill && !flush && retire && !chk_inflight;
   assign clr_fire     = refill && chk_inflight;

   assign alloc_id       = fifo[rd_ptr];
   assign query_inflight = iss_q ^ ret_q;
   assign inflight_count = (ID_W+1)'(MAX_IDS) - free_count;

   id_toggle_bank #(.N(MAX_IDS), .W(ID_W)) u_issue (
      .clk      (clk),
      .rst      (rst),
      .toggle   (alloc_fire),
      .toggle_id(alloc_id),
      .rd_a_id  (query_id),
      .rd_b_id  (chk_id),
      .rd_a     (iss_q),
      .rd_b     (iss_c)
   );

   // normal retire and refill clear share one toggle port; they are mutually exclusive by state
   id_toggle_bank #(.N(MAX_IDS), .W(ID_W)) u_retire (
      .clk      (clk),
      .rst      (rst),
      .toggle   (retire_fire || clr_fire),
      .toggle_id(chk_id),
      .rd_a_id  (query_id),
      .rd_b_id  (chk_id),
      .rd_a     (ret_q),
      .rd_b     (ret_c)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= NORMAL;
      else state <= state_nx;
   end

   // flush always (re)starts a refill; the last refill entry returns to normal
   always_comb begin
      state_nx = flush ? REFILL : (refill && last_idx) ? NORMAL : state;
   end

   // pool is unavailable while refilling
   always_comb begin
      busy         = refill;
      id_available = !refill && free_count != '0;
   end

   // free-list FIFO, pointers, count, refill index and sticky error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_IDS; i++) fifo[i] <= ID_W'(i);
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         free_count   <= (ID_W+1)'(MAX_IDS);
         idx          <= '0;
         retire_error <= 1'b0;
      end else if (refill) begin
         fifo[idx] <= idx;
         idx       <= (flush || last_idx) ? '0 : idx + 1'b1;
         if (last_idx && !flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            free_count <= (ID_W+1)'(MAX_IDS);
         end
      end else begin
         idx <= '0;
         if (retire_bad) retire_error <= 1'b1;
         if (alloc_fire) rd_ptr <= rd_ptr + 1'b1;
         if (retire_fire) begin
            fifo[wr_ptr] <= retire_id;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         free_count <= free_count + (ID_W+1)'(retire_fire) - (ID_W+1)'(alloc_fire);
      end
   end

endmodule

// File: tb/tb_id_allocator.sv
// tb_id_allocator: directed stimulus with a queue-based pool model and literal checks
module tb_id_allocator;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       alloc_req = 1'b0;
   logic       retire = 1'b0;
   logic [2:0] retire_id = '0;
   logic       flush = 1'b0;
   logic [2:0] query_id = '0;
   logic       id_available, busy, query_inflight, retire_error;
   logic [2:0] alloc_id;
   logic [3:0] inflight_count;

   int checks = 0;
   int errors = 0;

   id_allocator #(.MAX_IDS(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_req     (alloc_req),
      .id_available  (id_available),
      .alloc_id      (alloc_id),
      .retire        (retire),
      .retire_id     (retire_id),
      .flush         (flush),
      .busy          (busy),
      .query_id      (query_id),
      .query_inflight(query_inflight),
      .inflight_count(inflight_count),
      .retire_error  (retire_error)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // pool model: free IDs in grant order, in-flight flags, refill countdown
   int q[$];
   bit infl[N];
   bit err;
   int refill_left;
   bit m_a, m_r;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q = {};
         for (int i = 0; i < N; i++) begin q.push_back(i); infl[i] = 1'b0; end
         err = 1'b0;
         refill_left = 0;
      end else if (refill_left > 0) begin
         if (flush) refill_left = N;
         else begin
            refill_left--;
            if (refill_left == 0) begin
               q = {};
               for (int i = 0; i < N; i++) begin q.push_back(i); infl[i] = 1'b0; end
            end
         end
      end else if (flush) begin
         refill_left = N;
      end else begin
         m_a = alloc_req && q.size() > 0;
         m_r = retire && infl[retire_id];
         if (retire && !infl[retire_id]) err = 1'b1;
         if (m_a) begin infl[q[0]] = 1'b1; void'(q.pop_front()); end
         if (m_r) begin infl[retire_id] = 1'b0; q.push_back(int'(retire_id)); end
      end
   end

   // compare every cycle mid-period against the model
   bit m_busy;
   always @(negedge clk) begin
      if (!rst) begin
         m_busy = refill_left > 0;
         chk("busy", int'(busy), int'(m_busy));
         chk("id_available", int'(id_available), int'(!m_busy && q.size() > 0));
         chk("inflight_count", int'(inflight_count), N - q.size());
         chk("retire_error", int'(retire_error), int'(err));
         if (!m_busy && q.size() > 0) chk("alloc_id", int'(alloc_id), q[0]);
         if (!m_busy) chk("query_inflight", int'(query_inflight), int'(infl[query_id]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_retire(input int id);
      retire = 1'b1;
      retire_id = 3'(id);
      tick();
      retire = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #11 rst = 1'b0;
      #1;
      chk("rst busy", int'(busy), 0);
      chk("rst id_available", int'(id_available), 1);
      chk("rst alloc_id", int'(alloc_id), 0);
      chk("rst inflight_count", int'(inflight_count), 0);
      chk("rst retire_error", int'(retire_error), 0);
      chk("rst query_inflight", int'(query_inflight), 0);
      tick();
      // allocate everything, then one extra request with the pool empty
      alloc_req = 1'b1;
      for (int k = 0; k < N; k++) begin
         chk("seq alloc_id", int'(alloc_id), k);
         tick();
      end
      chk("empty id_available", int'(id_available), 0);
      chk("full inflight_count", int'(inflight_count), 8);
      tick();
      alloc_req = 1'b0;
      chk("still full", int'(inflight_count), 8);
      // retire 3 and 5, they come back in retire order
      query_id = 3'd3;
      do_retire(3);
      chk("query 3 after retire", int'(query_inflight), 0);
      do_retire(5);
      chk("realloc first", int'(alloc_id), 3);
      alloc_req = 1'b1;
      tick();
      chk("realloc second", int'(alloc_id), 5);
      tick();
      alloc_req = 1'b0;
      chk("realloc full", int'(inflight_count), 8);
      // count 4, then alloc and retire 2 together
      do_retire(0);
      do_retire(1);
      do_retire(3);
      do_retire(4);
      chk("four inflight", int'(inflight_count), 4);
      alloc_req = 1'b1;
      retire = 1'b1;
      retire_id = 3'd2;
      chk("grant not 2", int'(alloc_id), 0);
      tick();
      retire = 1'b0;
      chk("simul count", int'(inflight_count), 4);
      chk("tail order a", int'(alloc_id), 1);
      tick();
      chk("tail order b", int'(alloc_id), 3);
      tick();
      chk("tail order c", int'(alloc_id), 4);
      tick();
      chk("tail order d", int'(alloc_id), 2);
      tick();
      alloc_req = 1'b0;
      chk("drained", int'(inflight_count), 8);
      // invalid retire of a free ID sets the sticky error
      do_retire(6);
      do_retire(6);
      chk("bad retire error", int'(retire_error), 1);
      chk("bad retire count", int'(inflight_count), 7);
      do_retire(7);
      chk("valid after bad", int'(inflight_count), 6);
      chk("error sticky", int'(retire_error), 1);
      do_retire(0);
      chk("five inflight", int'(inflight_count), 5);
      // flush with requests held during refill: they must be ignored
      flush = 1'b1;
      tick();
      flush = 1'b0;
      alloc_req = 1'b1;
      retire = 1'b1;
      retire_id = 3'd1;
      for (int k = 0; k < N; k++) begin
         chk("refill busy", int'(busy), 1);
         chk("refill unavailable", int'(id_available), 0);
         tick();
      end
      alloc_req = 1'b0;
      retire = 1'b0;
      chk("post flush busy", int'(busy), 0);
      chk("post flush count", int'(inflight_count), 0);
      chk("post flush alloc_id", int'(alloc_id), 0);
      for (int k = 0; k < N; k++) begin
         query_id = 3'(k);
         #1 chk("post flush query", int'(query_inflight), 0);
      end
      // second flush at refill cycle 4 restarts the walk
      alloc_req = 1'b1;
      tick();
      tick();
      tick();
      alloc_req = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < N; k++) begin
         chk("restart busy", int'(busy), 1);
         tick();
      end
      chk("restart done", int'(busy), 0);
      chk("restart count", int'(inflight_count), 0);
      // async reset in the middle of a refill
      alloc_req = 1'b1;
      tick();
      tick();
      alloc_req = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tick();
      #1 rst = 1'b1;
      #1;
      chk("async busy", int'(busy), 0);
      chk("async id_available", int'(id_available), 1);
      chk("async alloc_id", int'(alloc_id), 0);
      chk("async count", int'(inflight_count), 0);
      #1 rst = 1'b0;
      tick();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_allocator.md
Name: id_allocator

Overview:
- Owns the instruction-ID pool of size MAX_IDS.
- Hands out free IDs at issue, takes them back at retire, and answers per-ID in-flight queries.
- Tracks the in-flight state of each ID with two per-ID toggle-bit banks: issue bank and retire bank, in-flight = issue XOR retire.
- Sits between decode/issue (allocation) and writeback/commit (retire); a flush from the branch/exception unit returns every ID to the pool.

Parameters:
- MAX_IDS, 8, number of IDs in the pool; power of two, at least 2.
- ID_W, $clog2(MAX_IDS), width of an ID (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alloc_req  in  1  issue stage requests an ID this cycle
- id_available  out  1  pool non-empty and not busy
- alloc_id  out  ID_W  ID granted when alloc_req && id_available
- retire  in  1  return retire_id to the pool
- retire_id  in  ID_W  ID being retired
- flush  in  1  return all IDs to the pool
- busy  out  1  refill in progress
- query_id  in  ID_W  ID to test
- query_inflight  out  1  query_id is currently allocated
- inflight_count  out  ID_W+1  number of allocated IDs
- retire_error  out  1  sticky; set on retire of an ID that is not in flight

Behaviour:
- Free list: circular FIFO, MAX_IDS entries of ID_W bits, with rd_ptr, wr_ptr (ID_W bits, natural wrap) and free_count (ID_W+1 bits).
- Async reset values:
  - fifo[i] = i; rd_ptr = 0; wr_ptr = 0; free_count = MAX_IDS.
  - Both toggle banks all 0; state = NORMAL.
  - Outputs: busy = 0, retire_error = 0, id_available = 1, alloc_id = 0, inflight_count = 0, query_inflight = 0.
- Combinational outputs:
  - alloc_id = fifo[rd_ptr].
  - id_available = (free_count != 0) && state == NORMAL.
  - query_inflight = issue[query_id] ^ retire[query_id], from registered state; it does not show same-cycle updates.
  - inflight_count = MAX_IDS - free_count.
- Allocation (alloc_req && id_available), registered on the edge:
  - rd_ptr++.
  - Toggle issue[alloc_id].
- Retire (retire && inflight(retire_id), in NORMAL):
  - fifo[wr_ptr] = retire_id; wr_ptr++.
  - Toggle retire[retire_id].
  - No bypass: a retired ID becomes allocatable the next cycle at the earliest, and only when it reaches the FIFO head.
- free_count update:
  - +1 on retire only; -1 on alloc only.
  - Unchanged when both occur in the same cycle; both pointers still advance.
  - Must never exceed MAX_IDS or go below 0; the guards above guarantee this.
- Invalid retire (retire && !inflight(retire_id)):
  - No FIFO write, no toggle, count unchanged.
  - retire_error <= 1, cleared only by rst.
- State machine NORMAL / REFILL:
  - NORMAL -> REFILL on flush. Any alloc/retire in the same cycle is dropped; flush has priority.
  - REFILL runs a counter idx from 0 to MAX_IDS-1, one entry per cycle. Each cycle:
    - fifo[idx] = idx.
    - If issue[idx] ^ retire[idx], toggle retire[idx].
  - After idx = MAX_IDS-1: rd_ptr = wr_ptr = 0, free_count = MAX_IDS, return to NORMAL.
  - busy = 1 for exactly MAX_IDS cycles.
  - In REFILL, alloc_req and retire are ignored, and retire_error is not updated.
  - flush during REFILL restarts idx at 0.
- rst asserted at any time, including mid-REFILL, immediately forces the reset values.

Decomposition:
- Shared package: id_t (logic [ID_W-1:0]), MAX_IDS, and the state enum id_alloc_state_t {NORMAL, REFILL}.
- Sub-module id_toggle_bank:
  - Per-ID toggle bit array with async reset to 0.
  - One toggle port (toggle, toggle_id) and two combinational read ports.
  - Instantiated twice, for the issue bank and the retire bank.
  - The REFILL clear drives the retire bank's toggle port, muxed with the normal retire path; the two are never active together.

Test Plan:
- Reset, then alloc_req held 9 cycles -> alloc_id 0..7 on cycles 1-8, id_available = 0 on cycle 9, inflight_count = 8.
- From full allocation, retire 3 then retire 5 -> query_inflight(3) = 0 the cycle after; next two allocs return 3 then 5.
- inflight_count = 4, alloc_req and retire(id 2) in the same cycle -> inflight_count stays 4; ID 2 is written at the FIFO tail and not granted that cycle.
- Retire ID 6 while not in flight -> retire_error = 1 and stays 1; free_count unchanged; later valid retires still work.
- 5 IDs in flight, flush -> busy = 1 and id_available = 0 for 8 cycles; then inflight_count = 0, alloc_id = 0, query_inflight = 0 for all IDs. Second flush at refill cycle 4 -> busy lasts 8 more cycles.
- rst pulsed asynchronously mid-REFILL -> busy = 0, id_available = 1, alloc_id = 0 immediately, without waiting for a clock edge.
